// File: rtl/wino_pkg.sv
// Shared types and Winograd F(4x4,3x3) output-transform coefficients.
package wino_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCUM,
      S_XROW,
      S_XCOL,
      S_HOLD
   } state_t;

   typedef enum logic {
      MODE_F43 = 1'b0,
      MODE_BYP = 1'b1
   } mode_t;

   // AT is 4x6; output rows/columns beyond row 3 are zero in F(4x4,3x3).
   localparam int AT_ROWS = 4;
   localparam int AT_COLS = 6;
   localparam int WINO_AT [AT_ROWS][AT_COLS] = '{
      '{1, 1,  1, 1,  1, 0},
      '{0, 1, -1, 2, -2, 0},
      '{0, 1,  1, 4,  4, 0},
      '{0, 1, -1, 8, -8, 1}
   };

endpackage

// File: rtl/wino_out_xform.sv
// One output-transform pass: Y = AT * X (mode F43) or Y = X (bypass).
// Coefficients are powers of two, so each term is a shift with optional negate.
// Elements are row-major, signed; the result saturates to OUT_W.
module wino_out_xform
   import wino_pkg::*;
#(
   parameter int TILE  = 6,
   parameter int IN_W  = 24,
   parameter int OUT_W = 28
) (
   input  mode_t                      i_mode,
   input  logic [TILE*TILE*IN_W-1:0]  i_x,
   output logic [TILE*TILE*OUT_W-1:0] o_y
);

   // Headroom: the largest AT row has |coef| sum of 19, i.e. 5 bits of growth.
   localparam int SW = ((IN_W > OUT_W) ? IN_W : OUT_W) + 6;

   function automatic logic signed [SW-1:0] cmul(input logic signed [IN_W-1:0] x, input int c);
      logic signed [SW-1:0] xe;
      xe = SW'(x);
      case (c)
         1:       cmul = xe;
         -1:      cmul = -xe;
         2:       cmul = xe <<< 1;
         -2:      cmul = -(xe <<< 1);
         4:       cmul = xe <<< 2;
         -4:      cmul = -(xe <<< 2);
         8:       cmul = xe <<< 3;
         -8:      cmul = -(xe <<< 3);
         default: cmul = '0;
      endcase
   endfunction

   function automatic logic [OUT_W-1:0] sat(input logic signed [SW-1:0] v);
      logic [SW-OUT_W:0] top_bits;
      top_bits = v[SW-1:OUT_W-1];
      if (&top_bits || ~|top_bits) sat = v[OUT_W-1:0];
      else if (v[SW-1])             sat = {1'b1, {(OUT_W-1){1'b0}}};
      else                          sat = {1'b0, {(OUT_W-1){1'b1}}};
   endfunction

   for (genvar r = 0; r < TILE; r++) begin : g_row
      for (genvar c = 0; c < TILE; c++) begin : g_col
         logic signed [SW-1:0] w_sum;
         logic signed [SW-1:0] w_byp;
         assign w_byp = SW'($signed(i_x[(r*TILE+c)*IN_W +: IN_W]));
         if (r < AT_ROWS) begin : g_at
            logic signed [SW-1:0] w_at;
            // Dot product of AT row r with column c of X
            always_comb begin
               w_at = '0;
               for (int k = 0; k < AT_COLS; k++)
                  w_at = w_at + cmul(i_x[(k*TILE+c)*IN_W +: IN_W], WINO_AT[r][k]);
            end
            assign w_sum = (i_mode == MODE_BYP) ? w_byp : w_at;
         end else begin : g_zero
            assign w_sum = (i_mode == MODE_BYP) ? w_byp : '0;
         end
         assign o_y[(r*TILE+c)*OUT_W +: OUT_W] = sat(w_sum);
      end
   end

endmodule

// File: rtl/wino_pe_acc.sv
// Winograd-domain PE: accumulates elementwise d*w products over input
// channels, then applies the output transform (AT*acc*A) and hands off the tile.
module wino_pe_acc
   import wino_pkg::*;
#(
   parameter int TILE       = 6,
   parameter int DATA_W     = 14,
   parameter int WGT_W      = 12,
   parameter int ACC_W      = 24,
   parameter int OUT_W      = 12,
   parameter int PROD_SHIFT = 7,
   parameter int OUT_SHIFT  = 4,
   parameter int ADDR_W     = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [TILE*TILE*DATA_W-1:0] in_data_i,
   input  logic [TILE*TILE*WGT_W-1:0]  in_wgt_i,
   input  logic                        in_valid_i,
   input  logic                        in_last_i,
   input  logic                        in_mode_i,
   input  logic [ADDR_W-1:0]           in_addr_i,
   output logic                        in_ready_o,
   output logic [TILE*TILE*OUT_W-1:0]  out_tile_o,
   output logic [ADDR_W-1:0]           out_addr_o,
   output logic                        out_valid_o,
   input  logic                        out_ready_i
);

   localparam int NE   = TILE*TILE;
   localparam int PW   = DATA_W + WGT_W;
   localparam int SUMW = ((PW > ACC_W) ? PW : ACC_W) + 1;
   localparam int RW   = ACC_W + 4;

   state_t                   r_state;
   mode_t                    r_mode;
   logic [ADDR_W-1:0]        r_addr;
   logic [NE-1:0][ACC_W-1:0] r_acc;
   logic [NE-1:0][ACC_W-1:0] w_acc_nxt;
   logic [NE*RW-1:0]         r_m, r_r;
   logic [NE*RW-1:0]         w_m_nxt, w_mt, w_yt, w_r_nxt;
   logic [NE-1:0][OUT_W-1:0] r_out_tile;
   logic [NE-1:0][OUT_W-1:0] w_out_nxt;
   logic [ADDR_W-1:0]        r_out_addr;
   logic                     r_out_valid;
   logic                     w_first;

   function automatic logic [ACC_W-1:0] sat_acc(input logic signed [SUMW-1:0] v);
      logic [SUMW-ACC_W:0] top_bits;
      top_bits = v[SUMW-1:ACC_W-1];
      if (&top_bits || ~|top_bits) sat_acc = v[ACC_W-1:0];
      else if (v[SUMW-1])           sat_acc = {1'b1, {(ACC_W-1){1'b0}}};
      else                          sat_acc = {1'b0, {(ACC_W-1){1'b1}}};
   endfunction

   function automatic logic [OUT_W-1:0] sat_out(input logic signed [RW-1:0] v);
      logic [RW-OUT_W:0] top_bits;
      top_bits = v[RW-1:OUT_W-1];
      if (&top_bits || ~|top_bits) sat_out = v[OUT_W-1:0];
      else if (v[RW-1])             sat_out = {1'b1, {(OUT_W-1){1'b0}}};
      else                          sat_out = {1'b0, {(OUT_W-1){1'b1}}};
   endfunction

   // The first beat of a job loads rather than adds.
   assign w_first = (r_state == S_IDLE);

   for (genvar e = 0; e < NE; e++) begin : g_mac
      logic signed [DATA_W-1:0] w_d;
      logic signed [WGT_W-1:0]  w_w;
      logic signed [PW-1:0]     w_prod, w_psh;
      logic signed [SUMW-1:0]   w_base, w_sum;
      assign w_d          = in_data_i[e*DATA_W +: DATA_W];
      assign w_w          = in_wgt_i[e*WGT_W +: WGT_W];
      assign w_prod       = PW'(w_d) * PW'(w_w);
      assign w_psh        = w_prod >>> PROD_SHIFT;
      assign w_base       = w_first ? '0 : SUMW'($signed(r_acc[e]));
      assign w_sum        = w_base + SUMW'(w_psh);
      assign w_acc_nxt[e] = sat_acc(w_sum);
   end

   // Column pass computes M*A as (AT * M^T)^T, reusing the same transform block.
   for (genvar a = 0; a < TILE; a++) begin : g_tra
      for (genvar b = 0; b < TILE; b++) begin : g_trb
         assign w_mt[(a*TILE+b)*RW +: RW]    = r_m[(b*TILE+a)*RW +: RW];
         assign w_r_nxt[(a*TILE+b)*RW +: RW] = w_yt[(b*TILE+a)*RW +: RW];
      end
   end

   wino_out_xform #(.TILE(TILE), .IN_W(ACC_W), .OUT_W(RW)) u_xrow (
      .i_mode (r_mode),
      .i_x    (r_acc),
      .o_y    (w_m_nxt)
   );

   wino_out_xform #(.TILE(TILE), .IN_W(RW), .OUT_W(RW)) u_xcol (
      .i_mode (r_mode),
      .i_x    (w_mt),
      .o_y    (w_yt)
   );

   for (genvar e = 0; e < NE; e++) begin : g_out
      logic signed [RW-1:0] w_rs;
      assign w_rs         = $signed(r_r[e*RW +: RW]) >>> OUT_SHIFT;
      assign w_out_nxt[e] = sat_out(w_rs);
   end

   // Control FSM with accumulator, transform pipeline and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_mode      <= MODE_F43;
         r_addr      <= '0;
         r_acc       <= '0;
         r_m         <= '0;
         r_r         <= '0;
         r_out_tile  <= '0;
         r_out_addr  <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid_i) begin
                  r_acc   <= w_acc_nxt;
                  r_mode  <= mode_t'(in_mode_i);
                  r_addr  <= in_addr_i;
                  r_state <= in_last_i ? S_XROW : S_ACCUM;
               end
            end
            S_ACCUM: begin
               if (in_valid_i) begin
                  r_acc <= w_acc_nxt;
                  if (in_last_i) r_state <= S_XROW;
               end
            end
            S_XROW: begin
               r_m     <= w_m_nxt;
               r_state <= S_XCOL;
            end
            S_XCOL: begin
               r_r     <= w_r_nxt;
               r_state <= S_HOLD;
            end
            S_HOLD: begin
               // First HOLD cycle registers the result; then wait for the consumer.
               if (!r_out_valid) begin
                  r_out_tile  <= w_out_nxt;
                  r_out_addr  <= r_addr;
                  r_out_valid <= 1'b1;
               end else if (out_ready_i) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready_o  = (r_state == S_IDLE) || (r_state == S_ACCUM);
   assign out_tile_o  = r_out_tile;
   assign out_addr_o  = r_out_addr;
   assign out_valid_o = r_out_valid;

endmodule

// File: tb/tb_wino_pe_acc.sv
// Scoreboard bench for wino_pe_acc with directed, hand-computed vectors.
module tb_wino_pe_acc;

   localparam int TILE   = 6;
   localparam int NE     = TILE*TILE;
   localparam int DATA_W = 14;
   localparam int WGT_W  = 12;
   localparam int OUT_W  = 12;
   localparam int ADDR_W = 8;

   typedef logic [NE*OUT_W-1:0] tile_t;
   typedef int tab_t [4][4];
   typedef struct {
      tile_t             tile;
      logic [ADDR_W-1:0] addr;
   } exp_t;

   logic                 clk;
   logic                 reset;
   logic [NE*DATA_W-1:0] in_data_i;
   logic [NE*WGT_W-1:0]  in_wgt_i;
   logic                 in_valid_i;
   logic                 in_last_i;
   logic                 in_mode_i;
   logic [ADDR_W-1:0]    in_addr_i;
   logic                 in_ready_o;
   tile_t                out_tile_o;
   logic [ADDR_W-1:0]    out_addr_o;
   logic                 out_valid_o;
   logic                 out_ready_i;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_err  = 0;
   int   n_out  = 0;
   int   n_push = 0;

   wino_pe_acc dut (
      .clk         (clk),
      .reset       (reset),
      .in_data_i   (in_data_i),
      .in_wgt_i    (in_wgt_i),
      .in_valid_i  (in_valid_i),
      .in_last_i   (in_last_i),
      .in_mode_i   (in_mode_i),
      .in_addr_i   (in_addr_i),
      .in_ready_o  (in_ready_o),
      .out_tile_o  (out_tile_o),
      .out_addr_o  (out_addr_o),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_tile(input string nm, input tile_t act, input tile_t exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [NE*DATA_W-1:0] ud(input int v);
      logic [NE*DATA_W-1:0] t;
      for (int e = 0; e < NE; e++) t[e*DATA_W +: DATA_W] = DATA_W'(v);
      return t;
   endfunction

   function automatic logic [NE*WGT_W-1:0] uw(input int v);
      logic [NE*WGT_W-1:0] t;
      for (int e = 0; e < NE; e++) t[e*WGT_W +: WGT_W] = WGT_W'(v);
      return t;
   endfunction

   function automatic tile_t ut(input int v);
      tile_t t;
      for (int e = 0; e < NE; e++) t[e*OUT_W +: OUT_W] = OUT_W'(v);
      return t;
   endfunction

   // Hand table for the 4x4 corner; rows/columns 4..5 stay zero.
   function automatic tile_t tab_tile(input tab_t tb);
      tile_t t;
      t = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            t[(r*TILE+c)*OUT_W +: OUT_W] = OUT_W'(tb[r][c]);
      return t;
   endfunction

   task automatic push(input tile_t t, input logic [ADDR_W-1:0] a);
      exp_t x;
      x.tile = t;
      x.addr = a;
      exp_q.push_back(x);
      n_push++;
   endtask

   // Present one beat and hold it until accepted; returns at posedge+1.
   task automatic send(input logic [NE*DATA_W-1:0] d, input logic [NE*WGT_W-1:0] w,
                       input logic last, input logic mode, input logic [ADDR_W-1:0] a);
      int n;
      in_data_i  = d;
      in_wgt_i   = w;
      in_last_i  = last;
      in_mode_i  = mode;
      in_addr_i  = a;
      in_valid_i = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready_o) break;
         n++;
         if (n > 50) begin
            chk("send_ready_timeout", 0, 1);
            @(posedge clk); #1;
            in_valid_i = 1'b0;
            in_last_i  = 1'b0;
            return;
         end
      end
      @(posedge clk); #1;
      in_valid_i = 1'b0;
      in_last_i  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Edges until out_valid_o is seen high, or -1 after a bounded wait.
   task automatic wait_out(output int lat);
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (out_valid_o) begin
            lat = i;
            break;
         end
      end
      if (lat < 0) chk("out_valid_timeout", 0, 1);
   endtask

   // Scoreboard monitor: every handshaken output is compared against the queue head.
   always @(negedge clk) begin
      if (!reset && out_valid_o && out_ready_i) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_out: got addr %0h with no expected result queued", out_addr_o);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            n_out++;
            chk_tile("out_tile", out_tile_o, e.tile);
            chk("out_addr", out_addr_o, e.addr);
         end
      end
   end

   initial begin
      int   lat;
      tab_t t3, t4, t7;
      logic [NE*DATA_W-1:0] dd;

      t3 = '{'{25, 0, 50, 5}, '{0, 0, 0, 0}, '{50, 0, 100, 10}, '{5, 0, 10, 1}};
      t4 = '{'{1, -2, 4, -8}, '{-2, 4, -8, 16}, '{4, -8, 16, -32}, '{-8, 16, -32, 64}};
      t7 = '{'{2047, 0, 2047, 2047}, '{0, 0, 0, 0}, '{2047, 0, 2047, 2047}, '{2047, 0, 2047, 2047}};

      reset       = 1'b1;
      in_data_i   = '0;
      in_wgt_i    = '0;
      in_valid_i  = 1'b0;
      in_last_i   = 1'b0;
      in_mode_i   = 1'b0;
      in_addr_i   = '0;
      out_ready_i = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_out_valid", out_valid_o, 0);
      chk("rst_in_ready", in_ready_o, 1);
      chk("rst_tile_nonzero", |out_tile_o, 0);
      chk("rst_out_addr", out_addr_o, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      idle(1);

      // Single beat, bypass: (128*64>>>7)>>>4 = 4, latency 3
      push(ut(4), 8'h11);
      send(ud(128), uw(64), 1'b1, 1'b1, 8'h11);
      wait_out(lat);
      chk("latency", lat, 3);
      idle(2);

      // Four beats with a gap; later beats carry mode 0 / other addresses that must be ignored
      push(ut(16), 8'h22);
      send(ud(128), uw(64), 1'b0, 1'b1, 8'h22);
      send(ud(128), uw(64), 1'b0, 1'b0, 8'h99);
      idle(2);
      send(ud(128), uw(64), 1'b0, 1'b0, 8'h77);
      send(ud(128), uw(64), 1'b1, 1'b0, 8'h66);
      wait_out(lat);
      idle(2);

      // F(4x4,3x3) on uniform acc = 16
      push(tab_tile(t3), 8'h33);
      send(ud(128), uw(16), 1'b1, 1'b0, 8'h33);
      wait_out(lat);
      idle(2);

      // F(4x4,3x3) on a single acc element (4,4) = 16
      dd = '0;
      dd[(4*TILE+4)*DATA_W +: DATA_W] = 14'd128;
      push(tab_tile(t4), 8'h44);
      send(dd, uw(16), 1'b1, 1'b0, 8'h44);
      wait_out(lat);
      idle(2);

      // Negative values floor on the arithmetic shift: -50 >>> 4 = -4
      push(ut(-4), 8'h45);
      send(ud(-100), uw(64), 1'b1, 1'b1, 8'h45);
      wait_out(lat);
      idle(2);

      // Back-pressure: result held, input blocked
      out_ready_i = 1'b0;
      push(ut(4), 8'h55);
      send(ud(128), uw(64), 1'b1, 1'b1, 8'h55);
      wait_out(lat);
      in_data_i  = ud(1000);
      in_wgt_i   = uw(1000);
      in_valid_i = 1'b1;
      in_last_i  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_valid", out_valid_o, 1);
         chk("hold_in_ready", in_ready_o, 0);
         chk_tile("hold_tile", out_tile_o, ut(4));
         chk("hold_addr", out_addr_o, 8'h55);
         @(posedge clk); #1;
      end
      in_valid_i  = 1'b0;
      in_last_i   = 1'b0;
      out_ready_i = 1'b1;
      idle(3);

      // Maximum-magnitude inputs over 16 beats
      push(ut(2047), 8'h66);
      for (int i = 0; i < 16; i++) send(ud(8191), uw(2047), i == 15, 1'b1, 8'h66);
      wait_out(lat);
      idle(2);
      push(ut(-2048), 8'h67);
      for (int i = 0; i < 16; i++) send(ud(-8192), uw(2047), i == 15, 1'b1, 8'h67);
      wait_out(lat);
      idle(2);
      push(tab_tile(t7), 8'h68);
      for (int i = 0; i < 16; i++) send(ud(-8192), uw(-2048), i == 15, 1'b0, 8'h68);
      wait_out(lat);
      idle(2);

      // Reset after 2 of 4 beats discards the job; fresh job is clean
      send(ud(128), uw(64), 1'b0, 1'b1, 8'h70);
      send(ud(128), uw(64), 1'b0, 1'b1, 8'h70);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready", in_ready_o, 1);
      chk("midrst_out_valid", out_valid_o, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      idle(2);
      push(ut(4), 8'h71);
      send(ud(128), uw(64), 1'b1, 1'b1, 8'h71);
      wait_out(lat);
      idle(2);

      // Reset in HOLD drops the pending result
      out_ready_i = 1'b0;
      send(ud(128), uw(64), 1'b1, 1'b1, 8'h72);
      wait_out(lat);
      reset = 1'b1;
      @(negedge clk);
      chk("holdrst_out_valid", out_valid_o, 0);
      chk("holdrst_tile_nonzero", |out_tile_o, 0);
      chk("holdrst_out_addr", out_addr_o, 0);
      @(posedge clk); #1;
      reset       = 1'b0;
      out_ready_i = 1'b1;
      idle(10);

      chk("queue_empty", exp_q.size(), 0);
      chk("out_count", n_out, n_push);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/wino_pe_acc.md
WINO_PE_ACC -- requirements
Module: wino_pe_acc

Interface
REQ-001 SHALL have parameter TILE, default 6, Winograd-domain tile edge.
REQ-002 SHALL have parameter DATA_W, default 14, signed transformed-input element width.
REQ-003 SHALL have parameter WGT_W, default 12, signed transformed-weight element width.
REQ-004 SHALL have parameter ACC_W, default 24, signed accumulator element width.
REQ-005 SHALL have parameter OUT_W, default 12, signed output element width.
REQ-006 SHALL have parameters PROD_SHIFT (default 7) and OUT_SHIFT (default 4), arithmetic right shifts applied to the product and the final result.
REQ-007 SHALL have parameter ADDR_W, default 8, result address width.
REQ-008 SHALL have ports, in order:
  clk  in  1  clock, rising edge
  reset  in  1  reset, asynchronous, active-high
  in_data_i  in  TILE*TILE*DATA_W  transformed input tile, row-major
  in_wgt_i  in  TILE*TILE*WGT_W  transformed weight tile, row-major
  in_valid_i  in  1  data/weight pair valid
  in_last_i  in  1  pair is the final input channel
  in_mode_i  in  1  0 = F(4x4,3x3), 1 = bypass (1x1 kernel, 6x6 output)
  in_addr_i  in  ADDR_W  result address for this accumulation
  in_ready_o  out  1  pair accepted this cycle when high with in_valid_i
  out_tile_o  out  TILE*TILE*OUT_W  result tile, row-major
  out_addr_o  out  ADDR_W  result address
  out_valid_o  out  1  result valid
  out_ready_i  in  1  downstream accepts result

Function
REQ-009 SHALL accept a pair ("beat") when in_valid_i and in_ready_o are both high at a rising edge.
REQ-010 SHALL implement states IDLE, ACCUM, XROW, XCOL, HOLD; in_ready_o SHALL be high only in IDLE and ACCUM.
REQ-011 In IDLE, a beat SHALL load acc[i][j] = (d[i][j]*w[i][j]) >>> PROD_SHIFT, latch in_mode_i and in_addr_i, and go to ACCUM; if in_last_i is also high, it SHALL go to XROW instead.
REQ-012 In ACCUM, a beat SHALL add its shifted product to acc, saturating to ACC_W; in_mode_i and in_addr_i of non-first beats SHALL be ignored; in_last_i SHALL move the block to XROW.
REQ-013 The product SHALL be full-precision signed (DATA_W+WGT_W bits) before the shift.
REQ-014 XROW SHALL register M = AT*acc, and XCOL SHALL register R = M*A, both in ACC_W+4 bits, each taking one cycle.
REQ-015 AT for mode 0 SHALL be rows [1 1 1 1 1 0], [0 1 -1 2 -2 0], [0 1 1 4 4 0], [0 1 -1 8 -8 1], computed with shifts and adds only (no multipliers); output rows and columns 4..5 SHALL be 0.
REQ-016 Mode 1 SHALL use AT = identity (R = acc).
REQ-017 Entering HOLD, out_tile_o SHALL be R >>> OUT_SHIFT saturated to OUT_W, out_addr_o SHALL be the latched address, and out_valid_o SHALL be 1.
REQ-018 Latency SHALL be 3 cycles from the last-beat edge to out_valid_o high.
REQ-019 In HOLD, outputs SHALL remain stable until out_ready_i is high at an edge; the block SHALL then clear out_valid_o and go to IDLE.
REQ-020 in_ready_o SHALL be combinational from state only, never from in_valid_i.
REQ-021 A cycle with in_valid_i low in ACCUM SHALL leave acc unchanged (channel gaps allowed).

Reset
REQ-022 Reset SHALL force state IDLE and zero acc, M, R, out_tile_o, out_addr_o, out_valid_o, and the latched mode/address.
REQ-023 Reset asserted mid-accumulation or in HOLD SHALL discard the partial or pending result; no out_valid_o pulse SHALL follow.

Structure
REQ-024 A shared package wino_pkg SHALL hold the state enum, the mode enum, and the AT coefficient constants.
REQ-025 Sub-module wino_out_xform (one AT or A pass, mode-selected) SHALL be instantiated once for the row pass and once for the column pass.

Verification
REQ-026 Single beat, mode 1: d = all 128, w = all 64, last = 1 -> after 3 cycles, every out element = ((128*64>>>7)>>>4) = 4.
REQ-027 Four beats, mode 1, d = 128, w = 64, with a 2-cycle valid gap -> every element = 16; out_valid_o asserts exactly once.
REQ-028 Mode 0, one beat making acc = all 16 -> rows/columns 4..5 of out = 0; out[0][0] = (25*16)>>>4 = 25; out[1][1] = 0.
REQ-029 out_ready_i held low for 5 cycles -> out_tile_o and out_addr_o are stable, in_ready_o is low, and no beat is accepted.
REQ-030 Maximum-magnitude inputs over 16 beats -> acc and outputs saturate to the ACC_W/OUT_W limits with no wrap.
REQ-031 Reset pulse after 2 of 4 beats -> no output; a following 1-beat job yields the correct fresh result.
